imem_port_arbiter: RTL and testbench
====================================

Name: imem_port_arbiter

Overview:
- Shares the single instruction-memory port (256 x 32-bit, word-indexed by address>>2, combinational read) between two requesters:
  - the CPU fetch unit, read-only;
  - the program loader/debug port, read/write.
- Picks one requester per cycle, drives the memory port and returns registered read data one cycle later.
- Supports a loader burst lock, guarantees loader forward progress, and flags misaligned or out-of-range accesses.

Parameters:
- DEPTH_W, 8, log2 of memory depth in words; valid word index is 0..2^DEPTH_W-1.
- STARVE_MAX, 4, consecutive loader denials after which the loader wins a contended cycle.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- f_req  input  1  fetch request.
- f_addr  input  32  fetch byte address.
- f_gnt  output  1  fetch accepted this cycle (combinational).
- f_rvalid  output  1  fetch read data valid (registered).
- f_rdata  output  32  fetch read data.
- f_err  output  1  with f_rvalid: access was misaligned or out of range.
- l_req  input  1  loader request.
- l_we  input  1  loader write enable (1 = write, 0 = read).
- l_lock  input  1  loader requests exclusive burst ownership.
- l_addr  input  32  loader byte address.
- l_wdata  input  32  loader write data.
- l_gnt  output  1  loader accepted this cycle (combinational).
- l_rvalid  output  1  loader response valid (reads and writes).
- l_rdata  output  32  loader read data; 0 for writes.
- l_err  output  1  with l_rvalid: misaligned or out of range.
- mem_addr  output  32  byte address to instruction memory.
- mem_we  output  1  memory write strobe.
- mem_wdata  output  32  memory write data.
- mem_rdata  input  32  memory read data (combinational from mem_addr).
- locked  output  1  arbiter is in LOCKED state.

Behaviour:
- Reset: asynchronous, active-low.
  - Clears all registered outputs: f_rvalid, f_rdata, f_err, l_rvalid, l_rdata, l_err, locked = 0.
  - Sets state = ARB and starve_cnt = 0.
  - Any response in flight is dropped; no rvalid after reset release.
- States:
  - ARB: normal arbitration.
  - LOCKED: loader-only access.
- Arbitration in ARB:
  - Only f_req: fetch granted.
  - Only l_req: loader granted; starve_cnt set to 0.
  - Both, starve_cnt < STARVE_MAX: fetch granted; starve_cnt increments.
  - Both, starve_cnt == STARVE_MAX: loader granted; starve_cnt set to 0.
  - l_req low: starve_cnt set to 0.
  - starve_cnt is 3 bits wide minimum and saturates at STARVE_MAX.
- Grant:
  - At most one gnt per cycle.
  - A request is accepted when req && gnt.
  - Requester inputs are held until gnt.
- Memory port:
  - mem_addr/mem_wdata follow the granted requester; when nothing is granted they follow fetch, with mem_we = 0.
  - mem_we = l_gnt & l_we & access_ok.
- Access checks:
  - access_ok = (addr[1:0] == 0) && (addr[31:DEPTH_W+2] == 0).
  - If not ok: request is still granted, no write, rdata = 0, err = 1.
- Response:
  - Cycle after acceptance: rvalid = 1 for exactly one cycle.
  - rdata = mem_rdata sampled at the accept edge.
  - Back-to-back accepts give back-to-back rvalid.
- Lock:
  - In ARB, an accepted loader request with l_lock = 1 moves to LOCKED next cycle.
  - In LOCKED: f_gnt = 0, loader granted whenever l_req, starve_cnt held at 0.
  - LOCKED returns to ARB in the cycle after l_lock samples 0.
  - locked mirrors state == LOCKED.
- Simultaneous events:
  - A loader accept with l_lock = 1 in the same cycle as a fetch accept is impossible, since there is only one grant.
  - l_lock dropping while l_req = 1 in LOCKED: that request is still granted in LOCKED, and arbitration resumes the next cycle.
- Latency: 0-cycle grant, 1-cycle response. No combinational path from mem_rdata to any output.

Optional Feature:
- IMEM_ARB_STATS_EN defined:
  - Adds outputs stat_fetch_cnt[31:0] (fetch accepts) and stat_stall_cnt[31:0] (cycles with f_req && !f_gnt).
  - Both reset to 0, wrap at 2^32, increment in the cycle after the event.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then fetch only:
  - Memory word 3 = 0xDEADBEEF, f_addr = 0x0C, f_req held 1 cycle.
  - Expect f_gnt = 1 the same cycle; next cycle f_rvalid = 1, f_rdata = 0xDEADBEEF, f_err = 0.
- Contention, STARVE_MAX = 4:
  - f_req and l_req held high continuously.
  - Expect fetch granted in cycles 0-3, loader in cycle 4, fetch in cycles 5-8, loader in cycle 9.
- Loader write then fetch:
  - l_we = 1, l_addr = 0x10, l_wdata = 0x12345678.
  - Expect mem_we pulse for one cycle; a later fetch of 0x10 returns 0x12345678.
- Burst lock:
  - Loader performs 3 writes with l_lock = 1 while f_req = 1.
  - Expect f_gnt = 0 and locked = 1 throughout the burst; after l_lock = 0, fetch granted on the next arbitration cycle.
- Errors:
  - Loader write to 0x02: expect no mem_we, l_err = 1.
  - Fetch of 0x400: expect f_err = 1, f_rdata = 0.
- Reset mid-operation:
  - Assert rst_n low in the accept cycle of a fetch.
  - Expect no f_rvalid after release and locked = 0.
  - With IMEM_ARB_STATS_EN: counters read 0 after reset.

Source files
------------

// File: rtl/imem_port_arbiter_if.sv
// Requester/memory bus of imem_port_arbiter: fetch port, loader port, instruction memory port.
// slave = arbiter side, master = requesters plus memory.
interface imem_port_arbiter_if;
    logic        f_req;
    logic [31:0] f_addr;
    logic        f_gnt;
    logic        f_rvalid;
    logic [31:0] f_rdata;
    logic        f_err;
    logic        l_req;
    logic        l_we;
    logic        l_lock;
    logic [31:0] l_addr;
    logic [31:0] l_wdata;
    logic        l_gnt;
    logic        l_rvalid;
    logic [31:0] l_rdata;
    logic        l_err;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  f_req, f_addr, l_req, l_we, l_lock, l_addr, l_wdata, mem_rdata,
        output f_gnt, f_rvalid, f_rdata, f_err, l_gnt, l_rvalid, l_rdata, l_err,
               mem_addr, mem_we, mem_wdata
    );

    modport master (
        output f_req, f_addr, l_req, l_we, l_lock, l_addr, l_wdata, mem_rdata,
        input  f_gnt, f_rvalid, f_rdata, f_err, l_gnt, l_rvalid, l_rdata, l_err,
               mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/imem_port_arbiter.sv
// Arbitrates one instruction-memory port between CPU fetch and the loader/debug port.
// Optional IMEM_ARB_STATS_EN adds fetch-accept and fetch-stall counters.
module imem_port_arbiter #(
    parameter int DEPTH_W    = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    imem_port_arbiter_if.slave bus,
    output logic locked
`ifdef IMEM_ARB_STATS_EN
    ,
    output logic [31:0] stat_fetch_cnt,
    output logic [31:0] stat_stall_cnt
`endif
);
    localparam int CW = ($clog2(STARVE_MAX + 1) > 3) ? $clog2(STARVE_MAX + 1) : 3;

    typedef enum logic {ARB, LOCKED} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] starve_cnt, starve_nxt;
    logic          f_gnt, l_gnt;
    logic          f_ok, l_ok, f_acc, l_acc;
    logic          f_rvalid, f_err, l_rvalid, l_err;
    logic [31:0]   f_rdata, l_rdata;

    assign f_ok  = (bus.f_addr[1:0] == 2'b00) && (bus.f_addr[31:DEPTH_W+2] == '0);
    assign l_ok  = (bus.l_addr[1:0] == 2'b00) && (bus.l_addr[31:DEPTH_W+2] == '0);
    assign f_acc = bus.f_req & f_gnt;
    assign l_acc = bus.l_req & l_gnt;

    always_comb begin
        f_gnt      = 1'b0;
        l_gnt      = 1'b0;
        state_nxt  = state;
        starve_nxt = starve_cnt;
        case (state)
            ARB: begin
                if (bus.f_req && bus.l_req) begin
                    if (starve_cnt == CW'(STARVE_MAX)) l_gnt = 1'b1;
                    else                               f_gnt = 1'b1;
                end else begin
                    f_gnt = bus.f_req;
                    l_gnt = bus.l_req;
                end
                // counts only contended cycles the loader lost; saturates at STARVE_MAX
                if (!bus.l_req || l_gnt)
                    starve_nxt = '0;
                else if (starve_cnt != CW'(STARVE_MAX))
                    starve_nxt = starve_cnt + CW'(1);
                if (l_acc && bus.l_lock) state_nxt = LOCKED;
            end
            LOCKED: begin
                l_gnt      = bus.l_req;
                starve_nxt = '0;
                if (!bus.l_lock) state_nxt = ARB;
            end
            default: state_nxt = ARB;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ARB;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
        end
    end

    // Read data is captured at the accept edge so mem_rdata never reaches an output combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_rvalid <= 1'b0;
            f_rdata  <= '0;
            f_err    <= 1'b0;
            l_rvalid <= 1'b0;
            l_rdata  <= '0;
            l_err    <= 1'b0;
        end else begin
            f_rvalid <= f_acc;
            f_err    <= f_acc & ~f_ok;
            if (f_acc) f_rdata <= f_ok ? bus.mem_rdata : '0;
            l_rvalid <= l_acc;
            l_err    <= l_acc & ~l_ok;
            if (l_acc) l_rdata <= (l_ok && !bus.l_we) ? bus.mem_rdata : '0;
        end
    end

`ifdef IMEM_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_fetch_cnt <= '0;
            stat_stall_cnt <= '0;
        end else begin
            if (f_acc)                 stat_fetch_cnt <= stat_fetch_cnt + 32'd1;
            if (bus.f_req && !f_gnt)   stat_stall_cnt <= stat_stall_cnt + 32'd1;
        end
    end
`endif

    assign bus.f_gnt     = f_gnt;
    assign bus.l_gnt     = l_gnt;
    assign bus.f_rvalid  = f_rvalid;
    assign bus.f_rdata   = f_rdata;
    assign bus.f_err     = f_err;
    assign bus.l_rvalid  = l_rvalid;
    assign bus.l_rdata   = l_rdata;
    assign bus.l_err     = l_err;
    assign bus.mem_addr  = l_gnt ? bus.l_addr : bus.f_addr;
    assign bus.mem_wdata = l_gnt ? bus.l_wdata : '0;
    assign bus.mem_we    = l_gnt & bus.l_we & l_ok;
    assign locked        = (state == LOCKED);
endmodule

// File: tb/tb_imem_port_arbiter.sv
// Self-checking bench for imem_port_arbiter: directed grant checks plus a response scoreboard
// backed by a reference copy of instruction memory.
module tb_imem_port_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    logic locked;
`ifdef IMEM_ARB_STATS_EN
    logic [31:0] stat_fetch_cnt, stat_stall_cnt;
    int unsigned exp_fetch, exp_stall;
`endif

    imem_port_arbiter_if bus ();

    imem_port_arbiter #(.DEPTH_W(8), .STARVE_MAX(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave),
        .locked(locked)
`ifdef IMEM_ARB_STATS_EN
        ,
        .stat_fetch_cnt(stat_fetch_cnt),
        .stat_stall_cnt(stat_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];

    assign bus.mem_rdata = mem[bus.mem_addr[9:2]];
    always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit aok(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a[31:10] == 22'd0);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Scoreboard entries are {err, rdata}.
    logic [32:0] fq[$];
    logic [32:0] lq[$];
    bit f_pend, l_pend;

    always @(negedge clk) begin
        if (rst_n) begin
            chk("gnt_excl", 32'(bus.f_gnt & bus.l_gnt), 32'd0);
            chk("mem_we", 32'(bus.mem_we),
                32'(bus.l_req && bus.l_gnt && bus.l_we && aok(bus.l_addr)));
            f_pend = bus.f_req && bus.f_gnt;
            l_pend = bus.l_req && bus.l_gnt;
            if (f_pend)
                fq.push_back({~aok(bus.f_addr),
                              aok(bus.f_addr) ? ref_mem[bus.f_addr[9:2]] : 32'd0});
            if (l_pend) begin
                if (bus.l_we) begin
                    lq.push_back({~aok(bus.l_addr), 32'd0});
                    if (aok(bus.l_addr)) ref_mem[bus.l_addr[9:2]] = bus.l_wdata;
                end else begin
                    lq.push_back({~aok(bus.l_addr),
                                  aok(bus.l_addr) ? ref_mem[bus.l_addr[9:2]] : 32'd0});
                end
            end
`ifdef IMEM_ARB_STATS_EN
            if (bus.f_req && bus.f_gnt)  exp_fetch++;
            if (bus.f_req && !bus.f_gnt) exp_stall++;
`endif
        end else begin
            f_pend = 1'b0;
            l_pend = 1'b0;
        end
    end

    always @(posedge clk) begin
        logic [32:0] e;
        #1;
        if (!rst_n) begin
            chk("rst_f_rvalid", 32'(bus.f_rvalid), 32'd0);
            chk("rst_l_rvalid", 32'(bus.l_rvalid), 32'd0);
            fq.delete();
            lq.delete();
            f_pend = 1'b0;
            l_pend = 1'b0;
`ifdef IMEM_ARB_STATS_EN
            exp_fetch = 0;
            exp_stall = 0;
            chk("rst_stat_fetch", stat_fetch_cnt, 32'd0);
            chk("rst_stat_stall", stat_stall_cnt, 32'd0);
`endif
        end else begin
            chk("f_rvalid", 32'(bus.f_rvalid), 32'(f_pend));
            chk("l_rvalid", 32'(bus.l_rvalid), 32'(l_pend));
            if (f_pend && fq.size() > 0) begin
                e = fq.pop_front();
                chk("f_rdata", bus.f_rdata, e[31:0]);
                chk("f_err", 32'(bus.f_err), 32'(e[32]));
            end
            if (l_pend && lq.size() > 0) begin
                e = lq.pop_front();
                chk("l_rdata", bus.l_rdata, e[31:0]);
                chk("l_err", 32'(bus.l_err), 32'(e[32]));
            end
`ifdef IMEM_ARB_STATS_EN
            chk("stat_fetch", stat_fetch_cnt, exp_fetch);
            chk("stat_stall", stat_stall_cnt, exp_stall);
`endif
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0;
        bus.f_req = 1'b0; bus.f_addr = '0;
        bus.l_req = 1'b0; bus.l_we = 1'b0; bus.l_lock = 1'b0;
        bus.l_addr = '0; bus.l_wdata = '0;
`ifdef IMEM_ARB_STATS_EN
        exp_fetch = 0;
        exp_stall = 0;
`endif
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 32'h1000_0000 + 32'(i);
            ref_mem[i] = 32'h1000_0000 + 32'(i);
        end
        mem[3]     = 32'hDEAD_BEEF;
        ref_mem[3] = 32'hDEAD_BEEF;

        // reset state
        repeat (3) cyc();
        chk("rst_f_rdata", bus.f_rdata, 32'd0);
        chk("rst_f_err", 32'(bus.f_err), 32'd0);
        chk("rst_l_rdata", bus.l_rdata, 32'd0);
        chk("rst_l_err", 32'(bus.l_err), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        rst_n = 1'b1;

        // fetch only
        cyc(); bus.f_req = 1'b1; bus.f_addr = 32'h0C;
        #2 chk("t1_f_gnt", 32'(bus.f_gnt), 32'd1);
        chk("t1_l_gnt", 32'(bus.l_gnt), 32'd0);
        cyc(); bus.f_req = 1'b0;
        #2 chk("t1_rvalid", 32'(bus.f_rvalid), 32'd1);
        chk("t1_rdata", bus.f_rdata, 32'hDEAD_BEEF);
        chk("t1_err", 32'(bus.f_err), 32'd0);

        // contention: loader wins every fifth cycle
        cyc();
        bus.f_req = 1'b1; bus.f_addr = 32'h20;
        bus.l_req = 1'b1; bus.l_we = 1'b0; bus.l_addr = 32'h24;
        for (int c = 0; c < 10; c++) begin
            #2;
            chk($sformatf("t2_f_gnt_c%0d", c), 32'(bus.f_gnt), 32'(c != 4 && c != 9));
            chk($sformatf("t2_l_gnt_c%0d", c), 32'(bus.l_gnt), 32'(c == 4 || c == 9));
            cyc();
        end
        bus.f_req = 1'b0; bus.l_req = 1'b0;

        // loader write, then fetch it back
        cyc(); bus.l_req = 1'b1; bus.l_we = 1'b1; bus.l_addr = 32'h10; bus.l_wdata = 32'h1234_5678;
        #2 chk("t3_l_gnt", 32'(bus.l_gnt), 32'd1);
        chk("t3_mem_we", 32'(bus.mem_we), 32'd1);
        cyc(); bus.l_req = 1'b0; bus.l_we = 1'b0;
        #2 chk("t3_mem_we_off", 32'(bus.mem_we), 32'd0);
        cyc(); bus.f_req = 1'b1; bus.f_addr = 32'h10;
        #2 chk("t3_f_gnt", 32'(bus.f_gnt), 32'd1);
        cyc(); bus.f_req = 1'b0;
        #2 chk("t3_fetch_data", bus.f_rdata, 32'h1234_5678);

        // burst lock against a continuously requesting fetch
        cyc();
        bus.f_req = 1'b1; bus.f_addr = 32'h0C;
        bus.l_req = 1'b1; bus.l_we = 1'b1; bus.l_lock = 1'b1;
        bus.l_addr = 32'h40; bus.l_wdata = 32'hA0;
        #2;
        n = 0;
        while (!bus.l_gnt && n < 8) begin
            cyc(); #2; n++;
        end
        chk("t4_lock_gnt", 32'(bus.l_gnt), 32'd1);
        for (int w = 1; w < 3; w++) begin
            cyc(); bus.l_addr = 32'h40 + 32'(4 * w); bus.l_wdata = 32'hA0 + 32'(w);
            #2 chk($sformatf("t4_locked_w%0d", w), 32'(locked), 32'd1);
            chk($sformatf("t4_f_gnt_w%0d", w), 32'(bus.f_gnt), 32'd0);
            chk($sformatf("t4_l_gnt_w%0d", w), 32'(bus.l_gnt), 32'd1);
        end
        cyc(); bus.l_req = 1'b0; bus.l_lock = 1'b0; bus.l_we = 1'b0;
        #2 chk("t4_locked_tail", 32'(locked), 32'd1);
        chk("t4_f_gnt_tail", 32'(bus.f_gnt), 32'd0);
        cyc();
        #2 chk("t4_unlocked", 32'(locked), 32'd0);
        chk("t4_f_gnt_resume", 32'(bus.f_gnt), 32'd1);
        cyc(); bus.f_req = 1'b0;

        // error accesses and boundary word
        bus.l_req = 1'b1; bus.l_we = 1'b1; bus.l_addr = 32'h02; bus.l_wdata = 32'hFFFF_FFFF;
        #2 chk("t5_l_gnt", 32'(bus.l_gnt), 32'd1);
        chk("t5_no_we", 32'(bus.mem_we), 32'd0);
        cyc(); bus.l_we = 1'b0; bus.l_addr = 32'h44;
        #2 chk("t5_l_err", 32'(bus.l_err), 32'd1);
        chk("t5_l_rdata0", bus.l_rdata, 32'd0);
        cyc(); bus.l_req = 1'b0; bus.f_req = 1'b1; bus.f_addr = 32'h400;
        #2 chk("t5_burst_read", bus.l_rdata, 32'hA1);
        chk("t5_f_gnt", 32'(bus.f_gnt), 32'd1);
        cyc(); bus.f_addr = 32'h3FC;
        #2 chk("t5_f_err", 32'(bus.f_err), 32'd1);
        chk("t5_f_rdata0", bus.f_rdata, 32'd0);
        cyc(); bus.f_req = 1'b0;
        #2 chk("t5_last_word_err", 32'(bus.f_err), 32'd0);
        chk("t5_last_word", bus.f_rdata, 32'h1000_00FF);

        // reset asserted in a fetch accept cycle
        cyc(); bus.f_req = 1'b1; bus.f_addr = 32'h0C;
        #4 rst_n = 1'b0; bus.f_req = 1'b0;
        cyc(); cyc();
        rst_n = 1'b1;
        #2 chk("t6_locked", 32'(locked), 32'd0);
        chk("t6_f_rvalid", 32'(bus.f_rvalid), 32'd0);
`ifdef IMEM_ARB_STATS_EN
        chk("t6_stat_fetch", stat_fetch_cnt, 32'd0);
        chk("t6_stat_stall", stat_stall_cnt, 32'd0);
`endif
        repeat (2) begin
            cyc();
            chk("t6_no_rvalid", 32'(bus.f_rvalid), 32'd0);
        end

        repeat (2) cyc();
        chk("fq_drained", 32'(fq.size()), 32'd0);
        chk("lq_drained", 32'(lq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
